// File: rtl/hilo_md_sequencer_pkg.sv
// ============================================================================
// Module   : hilo_md_sequencer_pkg
// Brief    : Shared state encodings, widths and select-bit indices for the
//            HI/LO multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hilo_md_sequencer_pkg;

    localparam int MD_DATA_W    = 32;
    localparam int MD_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam int MD_MULT_BIT  = 0;
    localparam int MD_MULTU_BIT = 1;
    localparam int MD_DIV_BIT   = 0;
    localparam int MD_DIVU_BIT  = 1;
    localparam int MD_MFLO_BIT  = 0;
    localparam int MD_MFHI_BIT  = 1;
    localparam int MD_MTLO_BIT  = 0;
    localparam int MD_MTHI_BIT  = 1;

    // Two's-complement negate when en is set; used for abs and result fix-up.
    function automatic logic [MD_DATA_W-1:0] md_cond_neg(
        input logic [MD_DATA_W-1:0] v,
        input logic                 en
    );
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_md_sequencer_div_step.sv
// ============================================================================
// Module   : div_restore_step
// Brief    : One combinational radix-2 restoring-divide iteration on
//            unsigned magnitudes; the caller owns all state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_restore_step
    import hilo_md_sequencer_pkg::*;
#(
    parameter int W = MD_DATA_W
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] w_rem_sh;
    logic [W:0] w_diff;

    // Remainder stays below the divisor, so W+1 bits hold the shifted trial.
    assign w_rem_sh = {rem_in, quo_in[W-1]};
    assign w_diff   = w_rem_sh - {1'b0, divisor};

    always_comb begin
        rem_out = w_rem_sh[W-1:0];
        quo_out = {quo_in[W-2:0], 1'b0};
        if (!w_diff[W]) begin
            rem_out = w_diff[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_md_sequencer.sv
// ============================================================================
// Module   : hilo_md_sequencer
// Brief    : HI/LO owner; fixed-latency multiply, iterative restoring divide,
//            pipeline stall. Option macro: HILO_MD_DIV0_FAST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hilo_md_sequencer
    import hilo_md_sequencer_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = MD_DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        flush,
    input  logic [1:0]  mult,
    input  logic [1:0]  div,
    input  logic [1:0]  mfhl,
    input  logic [1:0]  mthl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hl_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_sign;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_req_ok;
    logic        w_start;
    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;

    assign w_req_ok     = op_valid & ~flush;
    assign w_start      = w_req_ok & ((|mult) | (|div));
    assign w_div_signed = div[MD_DIV_BIT];
    assign w_abs_a      = md_cond_neg(src_a, w_div_signed & src_a[31]);
    assign w_abs_b      = md_cond_neg(src_b, w_div_signed & src_b[31]);

    div_restore_step #(
        .W (MD_DATA_W)
    ) u_div_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_b),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    // Sign-extend to 64 bits so one unsigned multiply covers both modes.
    assign w_a_ext   = {{32{r_sign & r_a[31]}}, r_a};
    assign w_b_ext   = {{32{r_sign & r_b[31]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_quo_fin = md_cond_neg(r_quo, r_neg_q);
    assign w_rem_fin = md_cond_neg(r_rem, r_neg_r);

    always_comb begin
        stall = 1'b0;
        case (r_state)
            MD_IDLE: stall = w_start;
            MD_MUL:  stall = ~flush;
            MD_DIV:  stall = ~flush;
            default: stall = 1'b0;
        endcase
    end

    assign busy     = (r_state != MD_IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign hl_rdata = mfhl[MD_MFHI_BIT] ? r_hi :
                      mfhl[MD_MFLO_BIT] ? r_lo : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MD_IDLE;
            r_cnt    <= 6'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_sign   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    r_cnt <= 6'd0;
                    if (w_start) begin
                        if (|div) begin
                            r_is_div <= 1'b1;
                            r_sign   <= w_div_signed;
                            // A zero divisor is positive, so only the dividend sign matters.
                            r_neg_q  <= w_div_signed & (src_a[31] ^ src_b[31]);
                            r_neg_r  <= w_div_signed & src_a[31];
                            r_b      <= w_abs_b;
`ifdef HILO_MD_DIV0_FAST_EN
                            if (src_b == 32'd0) begin
                                r_rem   <= w_abs_a;
                                r_quo   <= 32'hFFFF_FFFF;
                                r_state <= MD_DONE;
                            end else begin
                                r_rem   <= 32'd0;
                                r_quo   <= w_abs_a;
                                r_state <= MD_DIV;
                            end
`else
                            r_rem    <= 32'd0;
                            r_quo    <= w_abs_a;
                            r_state  <= MD_DIV;
`endif
                        end else begin
                            r_is_div <= 1'b0;
                            r_sign   <= mult[MD_MULT_BIT];
                            r_a      <= src_a;
                            r_b      <= src_b;
                            r_state  <= MD_MUL;
                        end
                    end else if (w_req_ok) begin
                        if (mthl[MD_MTHI_BIT]) r_hi <= src_a;
                        if (mthl[MD_MTLO_BIT]) r_lo <= src_a;
                    end
                end
                MD_MUL: begin
                    if (flush) begin
                        r_cnt   <= 6'd0;
                        r_state <= MD_IDLE;
                    end else if (r_cnt == 6'(MUL_LAT - 1)) begin
                        r_cnt   <= 6'd0;
                        r_state <= MD_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                MD_DIV: begin
                    if (flush) begin
                        r_cnt   <= 6'd0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == 6'(DIV_ITERS - 1)) begin
                            r_cnt   <= 6'd0;
                            r_state <= MD_DONE;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    r_cnt   <= 6'd0;
                    r_state <= MD_IDLE;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fin;
                            r_lo <= w_quo_fin;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_md_sequencer.sv
// ============================================================================
// Module   : tb_hilo_md_sequencer
// Brief    : Directed self-checking bench for hilo_md_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_md_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        flush;
    logic [1:0]  mult;
    logic [1:0]  div;
    logic [1:0]  mfhl;
    logic [1:0]  mthl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        busy;
    logic [31:0] hl_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

`ifdef HILO_MD_DIV0_FAST_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 33;
`endif

    always #5 clk = ~clk;

    hilo_md_sequencer #(
        .MUL_LAT   (2),
        .DIV_ITERS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .flush    (flush),
        .mult     (mult),
        .div      (div),
        .mfhl     (mfhl),
        .mthl     (mthl),
        .src_a    (src_a),
        .src_b    (src_b),
        .stall    (stall),
        .busy     (busy),
        .hl_rdata (hl_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, count stalled cycles, then check the committed HI/LO.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [1:0] d,
                          input logic [31:0] a, input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] hi_e, input logic [31:0] lo_e);
        int n;
        @(negedge clk);
        op_valid = 1'b1;
        mult     = m;
        div      = d;
        src_a    = a;
        src_b    = b;
        n        = 0;
        #1;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        op_valid = 1'b0;
        mult     = 2'b00;
        div      = 2'b00;
        @(posedge clk);
        #1;
        chk({tag, "_hi"}, hi, hi_e);
        chk({tag, "_lo"}, lo, lo_e);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        flush    = 1'b0;
        mult     = 2'b00;
        div      = 2'b00;
        mfhl     = 2'b00;
        mthl     = 2'b00;
        src_a    = 32'd0;
        src_b    = 32'd0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", hl_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_neg1x2", 2'b01, 2'b00, 32'hFFFF_FFFF, 32'd2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_ffx2",  2'b10, 2'b00, 32'hFFFF_FFFF, 32'd2, 3, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_min_sq", 2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000, 3, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7_2",    2'b00, 2'b01, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",    2'b00, 2'b01, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100_7",  2'b00, 2'b10, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu_10_0",   2'b00, 2'b10, 32'd10, 32'd0, DIV0_CYC, 32'h0000_000A, 32'hFFFF_FFFF);
        run_op("div_m10_0",   2'b00, 2'b01, 32'hFFFF_FFF6, 32'd0, DIV0_CYC, 32'hFFFF_FFF6, 32'h0000_0001);

        // mthi then mtlo, no stall; then read back through hl_rdata.
        @(negedge clk);
        op_valid = 1'b1;
        mthl     = 2'b10;
        src_a    = 32'h1234_5678;
        #1;
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        mthl     = 2'b01;
        src_a    = 32'h9ABC_DEF0;
        #1;
        chk("mtlo_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        mthl     = 2'b00;
        mfhl     = 2'b10;
        #1;
        chk("mfhi_rdata", hl_rdata, 32'h1234_5678);
        mfhl = 2'b01;
        #1;
        chk("mflo_rdata", hl_rdata, 32'h9ABC_DEF0);
        mfhl = 2'b00;
        #1;
        chk("mfnone_rdata", hl_rdata, 32'd0);

        // Flush a divide at T10.
        @(negedge clk);
        op_valid = 1'b1;
        div      = 2'b10;
        src_a    = 32'd100;
        src_b    = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        flush    = 1'b0;
        div      = 2'b00;
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hi", hi, 32'h1234_5678);
        chk("flush_lo", lo, 32'h9ABC_DEF0);
        chk("flush_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset pulse in the middle of a divide.
        @(negedge clk);
        op_valid = 1'b1;
        div      = 2'b01;
        src_a    = 32'hFFFF_FFF9;
        src_b    = 32'd2;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        op_valid = 1'b0;
        div      = 2'b00;
        #2;
        rst = 1'b0;

        run_op("mult_after_rst", 2'b10, 2'b00, 32'd6, 32'd7, 3, 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
